// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake and status/serial signals of the buffered UART transmitter.
// master = byte producer, slave = uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    wdata;
    logic          wvalid;
    logic          wready;
    logic [CW-1:0] count;
    logic          busy;
    logic          txd;

    modport master (
        output wdata,
        output wvalid,
        input  wready,
        input  count,
        input  busy,
        input  txd
    );

    modport slave (
        input  wdata,
        input  wvalid,
        output wready,
        output count,
        output busy,
        output txd
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser on txd.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit between data and stop).
module uart_tx_fifo #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int TW       = $clog2(BIT_CLKS);
    localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CLKS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    // Storage
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Serialiser
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_txd;
    logic          r_line_active;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    logic       w_ready;
    logic       w_push;
    logic       w_pop;
    logic       w_bit_end;
    logic [7:0] w_head;

    assign w_ready   = (r_count != CW'(FIFO_DEPTH));
    assign w_push    = bus.wvalid && w_ready;
    assign w_bit_end = (r_timer == BIT_LAST);
    assign w_head    = r_mem[r_rd_ptr];

    // A pop loads the shifter: from IDLE at once, or at the end of a stop bit for gapless frames.
    assign w_pop = (r_count != '0) &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    assign bus.wready = w_ready;
    assign bus.count  = r_count;
    assign bus.txd    = r_txd;
    // r_line_active covers the final registered stop-bit cycle after the FSM is back in IDLE.
    assign bus.busy   = (r_count != '0) || (r_state != S_IDLE) || r_line_active;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // txd is registered from the current state, so the line lags the FSM by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_txd         <= 1'b1;
            r_line_active <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity      <= 1'b0;
`endif
        end else begin
            r_line_active <= (r_state != S_IDLE);
            r_timer       <= r_timer + TW'(1);
            case (r_state)
                S_IDLE: begin
                    r_txd   <= 1'b1;
                    r_timer <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_txd <= 1'b0;
                    if (w_bit_end) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_txd <= r_shift[0];
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    r_txd <= r_parity;
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    r_txd <= 1'b1;
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_timer <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
